// File: rtl/lc3b_types.sv
// Shared types for the physical-memory arbiter: line/address widths,
// arbitration mode and FSM state encodings.
package lc3b_types;

  localparam int LC3B_ADDR_W = 16;
  localparam int LC3B_DATA_W = 256;

  typedef logic [LC3B_DATA_W-1:0] lc3b_block;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_select.sv
// Combinational winner selection: fixed priority from channel 0, or a
// round-robin scan starting at ptr and wrapping past NUM_CH-1.
module rr_select
  import lc3b_types::*;
#(
  parameter int NUM_CH = 2,
  localparam int PTR_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  input  arb_mode_e         mode,
  output logic [NUM_CH-1:0] gnt,
  output logic [PTR_W-1:0]  idx,
  output logic              valid
);

  always_comb begin
    int start;
    int cand;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    start = (mode == ARB_RR) ? int'(ptr) : 0;
    cand  = 0;
    // First requester found in scan order wins; later hits are masked by valid.
    for (int i = 0; i < NUM_CH; i++) begin
      cand = start + i;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (!valid && req[cand[PTR_W-1:0]]) begin
        valid                   = 1'b1;
        idx                     = cand[PTR_W-1:0];
        gnt[cand[PTR_W-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pmem_arbiter_n.sv
// N-channel physical-memory arbiter: grants one cache channel at a time,
// forwards its line request downstream and routes the completion back.
module pmem_arbiter_n
  import lc3b_types::*;
#(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = LC3B_ADDR_W,
  parameter int DATA_W  = $bits(lc3b_block),
  parameter int RR_MODE = 0,
  localparam int PTR_W  = $clog2(NUM_CH)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_CH-1:0]              ch_read,
  input  logic [NUM_CH-1:0]              ch_write,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_address,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_wdata,
  output logic [DATA_W-1:0]              ch_rdata,
  output logic [NUM_CH-1:0]              ch_resp,
  output logic                           mem_read,
  output logic                           mem_write,
  output logic [ADDR_W-1:0]              mem_address,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata,
  input  logic                           mem_resp,
  output logic                           proto_err,
  output arb_state_e                     dbg_state,
  output logic [PTR_W-1:0]               dbg_rr_ptr
);

  localparam arb_mode_e MODE = (RR_MODE == 1) ? ARB_RR : ARB_FIXED;

  // Handshake: a channel holds ch_read/ch_write as a level request; once
  // granted, the downstream request stays up until mem_resp, and that same
  // cycle ch_resp pulses for exactly one cycle to the granted channel.
  arb_state_e               state_q, state_d;
  logic [NUM_CH-1:0]        gnt_q, gnt_d;
  logic                     op_write_q, op_write_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic                     proto_err_q, proto_err_d;

  logic [NUM_CH-1:0]        sel_gnt;
  logic [PTR_W-1:0]         sel_idx;
  logic                     sel_valid;
  logic                     busy;

  rr_select #(.NUM_CH(NUM_CH)) u_sel (
    .req   (ch_read | ch_write),
    .ptr   (rr_ptr_q),
    .mode  (MODE),
    .gnt   (sel_gnt),
    .idx   (sel_idx),
    .valid (sel_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= '0;
      op_write_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rr_ptr_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      op_write_q  <= op_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rr_ptr_q    <= rr_ptr_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    op_write_d  = op_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rr_ptr_d    = rr_ptr_q;
    proto_err_d = proto_err_q | (|(ch_read & ch_write));
    case (state_q)
      ARB_IDLE: begin
        if (sel_valid) begin
          // Write wins when a channel raises both strobes.
          gnt_d      = sel_gnt;
          op_write_d = ch_write[sel_idx];
          addr_d     = ch_address[sel_idx];
          wdata_d    = ch_wdata[sel_idx];
          state_d    = ARB_BUSY;
          if (MODE == ARB_RR) begin
            rr_ptr_d = (sel_idx == PTR_W'(NUM_CH - 1)) ? '0 : sel_idx + PTR_W'(1);
          end
        end
      end
      ARB_BUSY: begin
        if (mem_resp) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign busy        = (state_q == ARB_BUSY);
  assign mem_read    = busy & ~op_write_q;
  assign mem_write   = busy & op_write_q;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign ch_rdata    = mem_rdata;
  assign ch_resp     = (busy && mem_resp) ? gnt_q : '0;
  assign proto_err   = proto_err_q;
  assign dbg_state   = state_q;
  assign dbg_rr_ptr  = rr_ptr_q;

endmodule

// File: tb/tb_pmem_arbiter_n.sv
// Bench for pmem_arbiter_n: a 2-channel fixed-priority instance and a
// 4-channel round-robin instance, checked against an expected-grant queue.
module tb_pmem_arbiter_n;
  import lc3b_types::*;

  localparam int AW = 16;
  localparam int DW = 256;
  localparam int EW = 3 + 1 + AW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // ---------------- fixed-priority DUT (2 channels) ----------------
  logic [1:0]          f_read, f_write, f_resp;
  logic [1:0][AW-1:0]  f_addr;
  logic [1:0][DW-1:0]  f_wdata;
  logic [DW-1:0]       f_rdata, f_mem_rdata, f_mem_wdata;
  logic                f_mem_read, f_mem_write, f_mem_resp, f_perr;
  logic [AW-1:0]       f_mem_addr;
  arb_state_e          f_dbg_state;
  logic [0:0]          f_dbg_ptr;

  pmem_arbiter_n #(.NUM_CH(2), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0)) dut_fixed (
    .clk(clk), .reset_n(reset_n),
    .ch_read(f_read), .ch_write(f_write), .ch_address(f_addr), .ch_wdata(f_wdata),
    .ch_rdata(f_rdata), .ch_resp(f_resp),
    .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_address(f_mem_addr),
    .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata), .mem_resp(f_mem_resp),
    .proto_err(f_perr), .dbg_state(f_dbg_state), .dbg_rr_ptr(f_dbg_ptr)
  );

  // ---------------- round-robin DUT (4 channels) ----------------
  logic [3:0]          r_read, r_write, r_resp;
  logic [3:0][AW-1:0]  r_addr;
  logic [3:0][DW-1:0]  r_wdata;
  logic [DW-1:0]       r_rdata, r_mem_rdata, r_mem_wdata;
  logic                r_mem_read, r_mem_write, r_mem_resp, r_perr;
  logic [AW-1:0]       r_mem_addr;
  arb_state_e          r_dbg_state;
  logic [1:0]          r_dbg_ptr;

  pmem_arbiter_n #(.NUM_CH(4), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1)) dut_rr (
    .clk(clk), .reset_n(reset_n),
    .ch_read(r_read), .ch_write(r_write), .ch_address(r_addr), .ch_wdata(r_wdata),
    .ch_rdata(r_rdata), .ch_resp(r_resp),
    .mem_read(r_mem_read), .mem_write(r_mem_write), .mem_address(r_mem_addr),
    .mem_wdata(r_mem_wdata), .mem_rdata(r_mem_rdata), .mem_resp(r_mem_resp),
    .proto_err(r_perr), .dbg_state(r_dbg_state), .dbg_rr_ptr(r_dbg_ptr)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input int ch, input bit wr, input logic [AW-1:0] a,
                                       input logic [DW-1:0] d);
    return {3'(ch), wr, a, d};
  endfunction

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_f_q[$];
  logic [EW-1:0] exp_r_q[$];
  logic [EW-1:0] f_e, r_e;
  logic [1:0]    f_oh;
  logic [3:0]    r_oh;

  always @(negedge clk) begin
    if (reset_n && f_resp != '0) begin
      if (exp_f_q.size() == 0) begin
        check("f_spurious_resp", EW'(f_resp), '0);
      end else begin
        f_e = exp_f_q.pop_front();
        for (int i = 0; i < 2; i++) f_oh[i] = (f_e[EW-1 -: 3] == 3'(i));
        check("f_resp_onehot", EW'(f_resp), EW'(f_oh));
        check("f_op", EW'({f_mem_write, f_mem_read}), EW'(f_e[AW+DW] ? 2'b10 : 2'b01));
        check("f_addr", EW'(f_mem_addr), EW'(f_e[DW +: AW]));
        if (f_e[AW+DW]) check("f_wdata", EW'(f_mem_wdata), EW'(f_e[DW-1:0]));
        check("f_rdata", EW'(f_rdata), EW'(f_mem_rdata));
      end
    end
    if (reset_n && r_resp != '0) begin
      if (exp_r_q.size() == 0) begin
        check("r_spurious_resp", EW'(r_resp), '0);
      end else begin
        r_e = exp_r_q.pop_front();
        for (int i = 0; i < 4; i++) r_oh[i] = (r_e[EW-1 -: 3] == 3'(i));
        check("r_resp_onehot", EW'(r_resp), EW'(r_oh));
        check("r_op", EW'({r_mem_write, r_mem_read}), EW'(r_e[AW+DW] ? 2'b10 : 2'b01));
        check("r_addr", EW'(r_mem_addr), EW'(r_e[DW +: AW]));
        check("r_rdata", EW'(r_rdata), EW'(r_mem_rdata));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Wait for the downstream request, then answer it lat cycles later for one cycle.
  // Returns at posedge+1 of the cycle after the response.
  task automatic serve(input bit rr, input int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!(rr ? (r_mem_read | r_mem_write) : (f_mem_read | f_mem_write)) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(rr ? "r_busy_timeout" : "f_busy_timeout", EW'(n < 20), EW'(1'b1));
    repeat (lat) @(posedge clk);
    #1;
    if (rr) begin
      r_mem_rdata = {8{$urandom()}};
      r_mem_resp  = 1'b1;
    end else begin
      f_mem_rdata = {8{$urandom()}};
      f_mem_resp  = 1'b1;
    end
    @(posedge clk);
    #1;
    f_mem_resp = 1'b0;
    r_mem_resp = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    f_read = '0; f_write = '0; f_addr = '0; f_wdata = '0; f_mem_rdata = '0; f_mem_resp = 1'b0;
    r_read = '0; r_write = '0; r_addr = '0; r_wdata = '0; r_mem_rdata = '0; r_mem_resp = 1'b0;
    reset_n = 1'b0;

    // Reset state
    #2;
    check("rst_op", EW'({f_mem_read, f_mem_write}), '0);
    check("rst_addr", EW'(f_mem_addr), '0);
    check("rst_wdata", EW'(f_mem_wdata), '0);
    check("rst_resp", EW'(f_resp), '0);
    check("rst_perr", EW'(f_perr), '0);
    check("rst_state", EW'(f_dbg_state), EW'(ARB_IDLE));
    check("rst_rr_ptr", EW'(r_dbg_ptr), '0);
    step();
    reset_n = 1'b1;

    // Two simultaneous reads, fixed priority: ch0 then ch1 with one dead cycle
    step();
    f_addr[0] = 16'h1000;
    f_addr[1] = 16'h2000;
    f_read    = 2'b11;
    exp_f_q.push_back(mk(0, 1'b0, 16'h1000, '0));
    exp_f_q.push_back(mk(1, 1'b0, 16'h2000, '0));
    @(negedge clk);
    check("a_idle_cycle", EW'({f_mem_read, f_mem_write}), '0);
    step();
    @(negedge clk);
    check("a_t1_read", EW'({f_mem_read, f_mem_write}), EW'(2'b10));
    check("a_t1_addr", EW'(f_mem_addr), EW'(16'h1000));
    serve(1'b0, 1);
    f_read = 2'b10;
    @(negedge clk);
    check("a_dead_cycle", EW'({f_mem_read, f_mem_write, f_resp}), '0);
    step();
    @(negedge clk);
    check("a_ch1_read", EW'({f_mem_read, f_mem_write}), EW'(2'b10));
    check("a_ch1_addr", EW'(f_mem_addr), EW'(16'h2000));
    serve(1'b0, 1);
    f_read = '0;

    // ch1 line write
    f_addr[1]  = 16'h0120;
    f_wdata[1] = '1;
    f_write    = 2'b10;
    exp_f_q.push_back(mk(1, 1'b1, 16'h0120, '1));
    step();
    @(negedge clk);
    check("b_write_op", EW'({f_mem_read, f_mem_write}), EW'(2'b01));
    check("b_write_addr", EW'(f_mem_addr), EW'(16'h0120));
    check("b_write_data", EW'(f_mem_wdata), EW'({DW{1'b1}}));
    serve(1'b0, 2);
    f_write = '0;

    // ch0 withdraws its read one cycle into the transaction
    f_addr[0] = 16'h0abc;
    f_read    = 2'b01;
    exp_f_q.push_back(mk(0, 1'b0, 16'h0abc, '0));
    step();
    f_read = '0;
    @(negedge clk);
    check("c_busy_read", EW'({f_mem_read, f_mem_write}), EW'(2'b10));
    check("c_busy_addr", EW'(f_mem_addr), EW'(16'h0abc));
    step();
    @(negedge clk);
    check("c_held_read", EW'(f_mem_read), EW'(1'b1));
    serve(1'b0, 1);

    // mem_resp while idle is ignored
    f_mem_resp = 1'b1;
    @(negedge clk);
    check("d_idle_resp", EW'(f_resp), '0);
    step();
    f_mem_resp = 1'b0;
    @(negedge clk);
    check("d_idle_state", EW'(f_dbg_state), EW'(ARB_IDLE));
    check("d_idle_op", EW'({f_mem_read, f_mem_write}), '0);

    // Read and write together on ch0: write wins, protocol error sticks
    f_addr[0]  = 16'h0055;
    f_wdata[0] = {8{32'hdeadbeef}};
    f_read     = 2'b01;
    f_write    = 2'b01;
    exp_f_q.push_back(mk(0, 1'b1, 16'h0055, {8{32'hdeadbeef}}));
    step();
    @(negedge clk);
    check("e_write_wins", EW'({f_mem_read, f_mem_write}), EW'(2'b01));
    check("e_perr_set", EW'(f_perr), EW'(1'b1));
    serve(1'b0, 1);
    f_read  = '0;
    f_write = '0;
    repeat (3) step();
    @(negedge clk);
    check("e_perr_sticky", EW'(f_perr), EW'(1'b1));

    // Round-robin: all four channels read continuously -> 0,1,2,3,0
    step();
    for (int i = 0; i < 4; i++) r_addr[i] = AW'(16'h4000 + i);
    r_read = 4'b1111;
    for (int k = 0; k < 5; k++) exp_r_q.push_back(mk(k % 4, 1'b0, AW'(16'h4000 + (k % 4)), '0));
    for (int k = 0; k < 5; k++) begin
      serve(1'b1, 2);
      if (k < 4) begin
        @(negedge clk);
        check("r_dead_cycle", EW'({r_mem_read, r_mem_write, r_resp}), '0);
      end
    end
    r_read = '0;
    @(negedge clk);
    check("r_ptr_after", EW'(r_dbg_ptr), EW'(2'd1));
    check("r_state_after", EW'(r_dbg_state), EW'(ARB_IDLE));

    // Reset asserted mid-transaction abandons it without a completion
    step();
    f_addr[0] = 16'h0777;
    f_read    = 2'b01;
    step();
    f_read = '0;
    @(negedge clk);
    check("f_pre_reset_busy", EW'(f_mem_read), EW'(1'b1));
    step();
    reset_n    = 1'b0;
    f_mem_resp = 1'b1;
    #1;
    check("g_rst_op", EW'({f_mem_read, f_mem_write}), '0);
    check("g_rst_addr", EW'(f_mem_addr), '0);
    check("g_rst_resp", EW'(f_resp), '0);
    check("g_rst_perr", EW'(f_perr), '0);
    check("g_rst_state", EW'(f_dbg_state), EW'(ARB_IDLE));
    check("g_rst_rr_ptr", EW'(r_dbg_ptr), '0);
    @(negedge clk);
    check("g_rst_resp_hold", EW'(f_resp), '0);
    step();
    reset_n    = 1'b1;
    f_mem_resp = 1'b0;
    @(negedge clk);
    check("g_post_state", EW'(f_dbg_state), EW'(ARB_IDLE));
    check("g_post_op", EW'({f_mem_read, f_mem_write}), '0);

    // Arbitration resumes after reset
    step();
    f_addr[1] = 16'h0888;
    f_read    = 2'b10;
    exp_f_q.push_back(mk(1, 1'b0, 16'h0888, '0));
    serve(1'b0, 1);
    f_read = '0;

    @(negedge clk);
    check("f_queue_drained", EW'(exp_f_q.size()), '0);
    check("r_queue_drained", EW'(exp_r_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
